// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and shared types for the VGA receive decoder.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_ACTIVE = 1'b0;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned H_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_START = DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned HCNT_W  = 11;
  localparam int unsigned VCNT_W  = 10;
  localparam int unsigned XY_W    = 10;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned ERR_W   = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Pixel-gated previous-sample register and assert-edge detector for one sync line.
module vga_sync_edge #(
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sync_in,
  output logic assert_c
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = prev_q;
    if (pix_en) prev_d = sync_in;
  end

  // Reset to the inactive level so a sync already active after reset counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= !SYNC_ACTIVE;
    else     prev_q <= prev_d;
  end

  assign assert_c = pix_en && (prev_q != SYNC_ACTIVE) && (sync_in == SYNC_ACTIVE);

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receiver: recovers pixel coordinates, frame boundaries and timing lock
// from sampled hsync/vsync/rgb on each pixel strobe.
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               pix_valid,
  output logic [XY_W-1:0]    x,
  output logic [XY_W-1:0]    y,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_start,
  output logic               locked,
  output logic               h_err,
  output logic               v_err,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_ST  = H_SYNC + H_BP;
  localparam int unsigned V_ST  = V_SYNC + V_BP;
  localparam int unsigned H_END = H_ST + H_ACTIVE;
  localparam int unsigned V_END = V_ST + V_ACTIVE;
  localparam int unsigned HX_W  = HCNT_W + 1;
  localparam int unsigned VX_W  = VCNT_W + 1;

  logic h_edge;
  logic v_edge;
  logic v_rst;
  logic h_in;
  logic v_in;

  rx_state_e          state_q,       state_d;
  logic [HCNT_W-1:0]  hcnt_q,        hcnt_d;
  logic [VCNT_W-1:0]  vcnt_q,        vcnt_d;
  logic               v_pend_q,      v_pend_d;
  logic               h_seen_q,      h_seen_d;
  logic               align_bad_q,   align_bad_d;
  logic               pix_valid_q,   pix_valid_d;
  logic [XY_W-1:0]    x_q,           x_d;
  logic [XY_W-1:0]    y_q,           y_d;
  logic [RGB_W-1:0]   rgb_q,         rgb_d;
  logic               frame_start_q, frame_start_d;
  logic               locked_q,      locked_d;
  logic               h_err_q,       h_err_d;
  logic               v_err_q,       v_err_d;
  logic [ERR_W-1:0]   err_cnt_q,     err_cnt_d;

  vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_hsync_edge (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .sync_in  (hsync),
    .assert_c (h_edge)
  );

  vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_vsync_edge (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .sync_in  (vsync),
    .assert_c (v_edge)
  );

  // A pending or coincident vsync edge is consumed by the next hsync edge.
  assign v_rst = h_edge && (v_pend_q || v_edge);
  assign h_in  = (hcnt_d >= HCNT_W'(H_ST)) && (hcnt_d < HCNT_W'(H_END));
  assign v_in  = (vcnt_d >= VCNT_W'(V_ST)) && (vcnt_d < VCNT_W'(V_END));

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    v_pend_d      = v_pend_q;
    h_seen_d      = h_seen_q;
    align_bad_d   = align_bad_q;
    pix_valid_d   = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    h_err_d       = 1'b0;
    v_err_d       = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (pix_en) begin
      h_err_d = h_edge && h_seen_q &&
                ((HX_W'(hcnt_q) + HX_W'(1)) != HX_W'(H_TOT));
      v_err_d = v_rst && (state_q != SEARCH) &&
                ((VX_W'(vcnt_q) + VX_W'(1)) != VX_W'(V_TOT));

      if (h_edge)              hcnt_d = '0;
      else if (hcnt_q != '1)   hcnt_d = hcnt_q + HCNT_W'(1);
      if (h_edge)              h_seen_d = 1'b1;

      if (v_rst)               v_pend_d = 1'b0;
      else if (v_edge)         v_pend_d = 1'b1;

      if (v_rst)                         vcnt_d = '0;
      else if (h_edge && vcnt_q != '1)   vcnt_d = vcnt_q + VCNT_W'(1);

      // Lock tracking: a clean ALIGN frame is required before LOCKED.
      case (state_q)
        SEARCH: begin
          if (v_rst) begin
            state_d     = ALIGN;
            align_bad_d = 1'b0;
          end
        end
        ALIGN: begin
          if (v_rst) begin
            if (!align_bad_q && !h_err_d && !v_err_d) state_d = LOCKED;
            align_bad_d = 1'b0;
          end else if (h_err_d) begin
            align_bad_d = 1'b1;
          end
        end
        LOCKED: begin
          if (h_err_d || v_err_d) begin
            state_d     = ALIGN;
            align_bad_d = 1'b0;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (h_in && v_in) begin
        x_d         = XY_W'(hcnt_d - HCNT_W'(H_ST));
        y_d         = XY_W'(vcnt_d - VCNT_W'(V_ST));
        rgb_d       = {r, g, b};
        pix_valid_d = (state_d == LOCKED);
      end
      frame_start_d = pix_valid_d && (x_d == '0) && (y_d == '0);

      if ((h_err_d || v_err_d) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      v_pend_q      <= 1'b0;
      h_seen_q      <= 1'b0;
      align_bad_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      v_pend_q      <= v_pend_d;
      h_seen_q      <= h_seen_d;
      align_bad_q   <= align_bad_d;
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Randomized bench for vga_rx_decoder on a scaled-down raster, checked against a per-pixel reference model.
module tb_vga_rx_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam bit SA = 1'b0;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int HST   = HS + HB;
  localparam int VST   = VS + VB;
  localparam int HMAX  = 2047;
  localparam int VMAX  = 1023;
  localparam int EARLY = 10;

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync, vsync;
  logic [3:0]  r, g, b;
  logic        pix_valid, frame_start, locked, h_err, v_err;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  logic [7:0]  err_cnt;

  vga_rx_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .x(x), .y(y), .rgb(rgb), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk, n_fail;
  // reference model state
  int m_h, m_v;
  bit m_hprev, m_vprev, m_hseen, m_vpend, m_align, m_lock, m_dirty;
  // expected outputs
  bit e_valid, e_fs, e_lock, e_herr, e_verr;
  int e_x, e_y, e_rgb, e_err;
  // per-section observations of the DUT
  int st_valid, st_fs, st_herr, st_verr, st_lock;
  int first_x, first_y, last_x, last_y;
  bit got_first;
  bit gap_mode;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0;
    m_hprev = 0; m_vprev = 0; m_hseen = 0; m_vpend = 0;
    m_align = 0; m_lock = 0; m_dirty = 0;
    e_valid = 0; e_fs = 0; e_lock = 0; e_herr = 0; e_verr = 0;
    e_x = 0; e_y = 0; e_rgb = 0; e_err = 0;
  endtask

  // One sampled pixel: hs_act/vs_act are the sync lines' "active" meaning, not their levels.
  task automatic model_pixel(input bit hs_act, input bit vs_act, input int pix_rgb);
    bit he, ve, vr, herr, verr;
    int nh, nv;
    he = hs_act && !m_hprev;
    ve = vs_act && !m_vprev;
    m_hprev = hs_act;
    m_vprev = vs_act;
    herr = he && m_hseen && (m_h + 1 != HT);
    if (he) m_hseen = 1;
    nh = he ? 0 : ((m_h < HMAX) ? m_h + 1 : HMAX);
    if (ve) m_vpend = 1;
    vr = he && m_vpend;
    verr = vr && (m_align || m_lock) && (m_v + 1 != VT);
    nv = m_v;
    if (vr) begin
      nv = 0;
      m_vpend = 0;
    end else if (he) begin
      nv = (m_v < VMAX) ? m_v + 1 : VMAX;
    end
    if (m_lock) begin
      if (herr || verr) begin m_lock = 0; m_align = 1; m_dirty = 0; end
    end else if (m_align) begin
      if (vr) begin
        if (!m_dirty && !herr && !verr) begin m_lock = 1; m_align = 0; end
        m_dirty = 0;
      end else if (herr) begin
        m_dirty = 1;
      end
    end else if (vr) begin
      m_align = 1;
      m_dirty = 0;
    end
    m_h = nh;
    m_v = nv;
    e_herr = herr;
    e_verr = verr;
    if (herr || verr) e_err = (e_err < 255) ? e_err + 1 : 255;
    e_lock = m_lock;
    e_valid = 0;
    e_fs = 0;
    if (nh >= HST && nh < HST + HA && nv >= VST && nv < VST + VA) begin
      e_x = nh - HST;
      e_y = nv - VST;
      e_rgb = pix_rgb;
      e_valid = m_lock;
      e_fs = m_lock && (e_x == 0) && (e_y == 0);
    end
  endtask

  task automatic check_outputs();
    chk("pix_valid",   int'(pix_valid),   int'(e_valid));
    chk("x",           int'(x),           e_x);
    chk("y",           int'(y),           e_y);
    chk("rgb",         int'(rgb),         e_rgb);
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("locked",      int'(locked),      int'(e_lock));
    chk("h_err",       int'(h_err),       int'(e_herr));
    chk("v_err",       int'(v_err),       int'(e_verr));
    chk("err_cnt",     int'(err_cnt),     e_err);
  endtask

  task automatic stats_clear();
    st_valid = 0; st_fs = 0; st_herr = 0; st_verr = 0; st_lock = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; got_first = 0;
  endtask

  task automatic idle_cycle();
    pix_en = 1'b0;
    @(posedge clk); #1;
    e_valid = 0; e_fs = 0; e_herr = 0; e_verr = 0;
    check_outputs();
  endtask

  task automatic put_pixel(input bit hs_act, input bit vs_act, input int pix_rgb, input int gap,
                           input bit geo, input int gx, input int gy, input bit grad);
    hsync = hs_act ? SA : !SA;
    vsync = vs_act ? SA : !SA;
    {r, g, b} = 12'(pix_rgb);
    pix_en = 1'b1;
    model_pixel(hs_act, vs_act, pix_rgb);
    @(posedge clk); #1;
    check_outputs();
    st_valid += int'(pix_valid);
    st_fs    += int'(frame_start);
    st_herr  += int'(h_err);
    st_verr  += int'(v_err);
    st_lock  += int'(locked);
    if (pix_valid) begin
      if (!got_first) begin first_x = int'(x); first_y = int'(y); got_first = 1; end
      last_x = int'(x);
      last_y = int'(y);
      if (geo) begin
        chk("geo_x", int'(x), gx);
        chk("geo_y", int'(y), gy);
      end
      if (grad) chk("grad_rgb", int'(rgb), ((gx & 15) << 8) | ((gy & 15) << 4) | 10);
    end
    if (h_err || v_err) chk("lock_drop", int'(locked), 0);
    pix_en = 1'b0;
    repeat (gap) idle_cycle();
  endtask

  // Lines v0..v1-1 of a frame of nlines lines; short_line loses its last pixel,
  // early_next starts the next frame's vsync EARLY pixels before the frame ends.
  task automatic run_lines(input int v0, input int v1, input int nlines, input int short_line,
                           input bit early_next, input bit geo, input bit grad);
    for (int vc = v0; vc < v1; vc++) begin
      int len;
      len = (vc == short_line) ? HT - 1 : HT;
      for (int hc = 0; hc < len; hc++) begin
        bit hs, vs;
        int px, gap;
        hs = (hc < HS);
        vs = (vc < VS) || (early_next && vc == nlines - 1 && hc >= len - EARLY);
        px = grad ? ((((hc - HST) & 15) << 8) | (((vc - VST) & 15) << 4) | 10)
                  : int'($urandom_range(0, 4095));
        gap = gap_mode ? int'($urandom_range(0, 3)) : 1;
        put_pixel(hs, vs, px, gap, geo, hc - HST, vc - VST, grad);
      end
    end
  endtask

  task automatic run_frame(input int nlines, input int short_line, input bit early_next,
                           input bit geo, input bit grad);
    run_lines(0, nlines, nlines, short_line, early_next, geo, grad);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; pix_en = 1'b0; hsync = !SA; vsync = !SA; r = '0; g = '0; b = '0;
    gap_mode = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check_outputs();
    end
    rst = 1'b0;

    // Two ideal frames, one pixel every second clock.
    stats_clear();
    run_frame(VT, -1, 0, 0, 0);
    chk("f1_locked_pixels", st_lock, 0);
    stats_clear();
    run_frame(VT, -1, 0, 1, 0);
    chk("f2_locked_pixels", st_lock, VT * HT);
    chk("f2_valid_count", st_valid, HA * VA);
    chk("f2_frame_start", st_fs, 1);
    chk("f2_first_x", first_x, 0);
    chk("f2_first_y", first_y, 0);
    chk("f2_last_x", last_x, HA - 1);
    chk("f2_last_y", last_y, VA - 1);
    chk("f2_errs", st_herr + st_verr, 0);

    // Short line while locked, then relock.
    gap_mode = 1;
    stats_clear();
    run_frame(VT, 3, 0, 0, 0);
    chk("short_herr", st_herr, 1);
    chk("short_err_cnt", int'(err_cnt), 1);
    chk("short_locked_end", int'(locked), 0);
    stats_clear();
    run_frame(VT, -1, 0, 1, 0);
    chk("relock_pixels", st_lock, VT * HT);
    chk("relock_valid", st_valid, HA * VA);

    // Frame one line short.
    stats_clear();
    run_frame(VT - 1, -1, 0, 0, 0);
    chk("short_frame_errs", st_herr + st_verr, 0);
    stats_clear();
    run_frame(VT, -1, 0, 0, 0);
    chk("vframe_verr", st_verr, 1);
    chk("vframe_locked_pixels", st_lock, 0);
    chk("vframe_err_cnt", int'(err_cnt), 2);
    stats_clear();
    run_frame(VT, -1, 0, 1, 0);
    chk("vrelock_pixels", st_lock, VT * HT);

    // Gradient colour frame.
    stats_clear();
    run_frame(VT, -1, 0, 1, 1);
    chk("grad_valid", st_valid, HA * VA);

    // Vsync asserted EARLY pixels ahead of the hsync edge.
    stats_clear();
    run_frame(VT, -1, 1, 1, 0);
    chk("pre_early_valid", st_valid, HA * VA);
    stats_clear();
    run_frame(VT, -1, 0, 1, 0);
    chk("early_valid", st_valid, HA * VA);
    chk("early_errs", st_herr + st_verr, 0);
    chk("early_first_y", first_y, 0);
    chk("early_last_y", last_y, VA - 1);

    // Reset part-way through a locked frame.
    run_lines(0, 5, VT, -1, 0, 0, 0);
    rst = 1'b1;
    pix_en = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_outputs();
    rst = 1'b0;
    stats_clear();
    run_lines(5, VT, VT, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 0, 0);
    chk("post_rst_locked_pixels", st_lock, 0);
    stats_clear();
    run_frame(VT, -1, 0, 1, 0);
    chk("post_rst_relock", st_lock, VT * HT);
    chk("post_rst_valid", st_valid, HA * VA);

    // Missing hsync: counter saturates silently, the late edge reports one error.
    stats_clear();
    repeat (2100) put_pixel(0, 0, int'($urandom_range(0, 4095)), 0, 0, 0, 0, 0);
    chk("missing_quiet", st_herr + st_verr, 0);
    put_pixel(1, 0, 0, 0, 0, 0, 0, 0);
    put_pixel(0, 0, 0, 0, 0, 0, 0, 0);
    chk("missing_herr", st_herr, 1);

    // Error storm saturates the error counter.
    stats_clear();
    repeat (302) begin
      for (int hc = 0; hc < 5; hc++) put_pixel(hc == 0, 0, int'($urandom_range(0, 4095)), 0, 0, 0, 0, 0);
    end
    chk("storm_herr", st_herr, 302);
    chk("storm_err_cnt", int'(err_cnt), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
